led_fb_arbiter: RTL and testbench

- Sequences the panel frame memory for the 64x64 HUB75 path.
- Shares one single-port synchronous RAM between the ledscan read requester and a host pixel writer. The ledscan requester has hard real-time priority.
- Adds page flipping at frame boundaries and a background page-clear sequencer.
- Sits between ledscan and the frame RAM, which replaces the static sprite ROM.

---
 rtl/led_fb_pkg.sv | 34 +++
 rtl/led_fb_arbiter_if.sv | 15 +
 rtl/led_fb_wr_fifo.sv | 50 +++++
 rtl/led_fb_arbiter.sv | 149 ++++++++++++++
 tb/tb_led_fb_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_fb_pkg.sv
// Shared types and sizes for the HUB75 frame-RAM arbiter: word/address types,
// FSM states and the registered RAM request.
package led_fb_pkg;

    localparam int ADDR_W = 11;
    localparam int PIX_W  = 24;
    localparam int WORD_W = 2 * PIX_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // One RAM port cycle; page selects front/back half of the frame RAM.
    typedef struct packed {
        logic       page;
        addr_t      addr;
        logic       we;
        logic [1:0] be;
        word_t      wdata;
    } mem_req_t;

    // A host write with its destination page already resolved.
    typedef struct packed {
        logic       page;
        addr_t      addr;
        logic [1:0] be;
        word_t      data;
    } wr_entry_t;

endpackage

// File: rtl/led_fb_arbiter_if.sv
// Host pixel-write handshake into the frame-RAM arbiter.
// master = host writer, slave = arbiter.
interface led_fb_arbiter_if;
    import led_fb_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    addr_t      wr_addr;
    logic [1:0] wr_be;
    word_t      wr_data;

    modport master (output wr_valid, wr_addr, wr_be, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_be, wr_data, output wr_ready);

endinterface

// File: rtl/led_fb_wr_fifo.sv
// Small synchronous FIFO buffering host writes ahead of the arbiter.
// DEPTH must be a power of two so the pointers wrap naturally.
module led_fb_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // NOTE: storage has no reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/led_fb_arbiter.sv
// Frame-RAM arbiter for the 64x64 HUB75 path: scan reads (hard priority), page
// clear, host writes, frame-aligned page flip. Optional write skid FIFO: LED_FB_WR_SKID_EN.
module led_fb_arbiter
    import led_fb_pkg::*;
#(
    parameter logic [PIX_W-1:0] CLR_COLOR = 24'h000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_req_i,
    input  addr_t            scan_addr_i,
    input  logic             scan_frame_start_i,
    output logic             scan_rvalid_o,
    output word_t            scan_rdata_o,
    led_fb_arbiter_if.slave  wr_if,
    input  logic             swap_req_i,
    output logic             swap_done_o,
    input  logic             clr_req_i,
    output logic             clr_busy_o,
    output logic             front_page_o,
    output logic [ADDR_W:0]  mem_addr_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_be_o,
    output word_t            mem_wdata_o,
    input  word_t            mem_rdata_i
);

    state_e    state_q;
    addr_t     clr_cnt_q;
    logic      front_q;
    logic      pending_q;
    logic      swap_done_q;
    logic [1:0] rd_pipe_q;
    mem_req_t  req_q, req_d;

    logic      host_go;
    wr_entry_t host_entry;
    logic      flip_ok;
    logic      flip;

`ifdef LED_FB_WR_SKID_EN
    logic                         fifo_full, fifo_empty, fifo_push;
    logic [$bits(wr_entry_t)-1:0] fifo_din, fifo_dout;

    assign wr_if.wr_ready = !fifo_full && (state_q == IDLE);
    assign fifo_push      = wr_if.wr_valid && wr_if.wr_ready;
    assign fifo_din       = {~front_q, wr_if.wr_addr, wr_if.wr_be, wr_if.wr_data};
    // Drain only on cycles neither scan nor clear wants the port.
    assign host_go        = !scan_req_i && (state_q != CLEAR) && !fifo_empty;
    assign host_entry     = wr_entry_t'(fifo_dout);
    assign flip_ok        = fifo_empty;

    led_fb_wr_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (4)
    ) u_wr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (host_go),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign wr_if.wr_ready = !scan_req_i && (state_q == IDLE);
    assign host_go        = wr_if.wr_valid && wr_if.wr_ready;
    assign host_entry     = '{page: ~front_q, addr: wr_if.wr_addr, be: wr_if.wr_be, data: wr_if.wr_data};
    assign flip_ok        = 1'b1;
`endif

    // Flip only at a frame start, never while the back page is being cleared.
    assign flip = scan_frame_start_i && (pending_q || swap_req_i) && (state_q != CLEAR) && flip_ok;

    always_comb begin
        // NOTE: defaults first so every path assigns req_d and no latch is inferred.
        req_d    = req_q;
        req_d.we = 1'b0;
        req_d.be = 2'b00;
        if (scan_req_i) begin
            req_d.page = front_q;
            req_d.addr = scan_addr_i;
        end else if (state_q == CLEAR) begin
            req_d.page  = ~front_q;
            req_d.addr  = clr_cnt_q;
            req_d.we    = 1'b1;
            req_d.be    = 2'b11;
            req_d.wdata = {CLR_COLOR, CLR_COLOR};
        end else if (host_go) begin
            req_d.page  = host_entry.page;
            req_d.addr  = host_entry.addr;
            req_d.we    = 1'b1;
            req_d.be    = host_entry.be;
            req_d.wdata = host_entry.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            rd_pipe_q   <= 2'b00;
            req_q       <= '0;
        end else begin
            req_q       <= req_d;
            rd_pipe_q   <= {rd_pipe_q[0], scan_req_i};
            swap_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
                CLEAR: begin
                    if (!scan_req_i) begin
                        clr_cnt_q <= clr_cnt_q + addr_t'(1);
                        if (clr_cnt_q == '1) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (flip) begin
                front_q     <= ~front_q;
                pending_q   <= 1'b0;
                swap_done_q <= 1'b1;
            end else if (swap_req_i) begin
                pending_q   <= 1'b1;
            end
        end
    end

    assign scan_rvalid_o = rd_pipe_q[1];
    assign scan_rdata_o  = rd_pipe_q[1] ? mem_rdata_i : '0;
    assign swap_done_o   = swap_done_q;
    assign clr_busy_o    = (state_q == CLEAR);
    assign front_page_o  = front_q;
    assign mem_addr_o    = {req_q.page, req_q.addr};
    assign mem_we_o      = req_q.we;
    assign mem_be_o      = req_q.be;
    assign mem_wdata_o   = req_q.wdata;

endmodule

// File: tb/tb_led_fb_arbiter.sv
// Self-checking bench for led_fb_arbiter: randomized traffic against a frame-level
// reference model, with a queue scoreboard checked by an independent RAM-port monitor.
module tb_led_fb_arbiter;
    import led_fb_pkg::*;

    localparam int NWORDS = 1 << ADDR_W;
    localparam logic [PIX_W-1:0] CLR = 24'h000000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            scan_req, scan_frame_start, swap_req, clr_req;
    addr_t           scan_addr;
    logic            scan_rvalid, swap_done, clr_busy, front_page;
    word_t           scan_rdata;
    logic [ADDR_W:0] mem_addr;
    logic            mem_we;
    logic [1:0]      mem_be;
    word_t           mem_wdata, mem_rdata;

    led_fb_arbiter_if wr_bus();

    led_fb_arbiter #(.CLR_COLOR(CLR)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .scan_req_i         (scan_req),
        .scan_addr_i        (scan_addr),
        .scan_frame_start_i (scan_frame_start),
        .scan_rvalid_o      (scan_rvalid),
        .scan_rdata_o       (scan_rdata),
        .wr_if              (wr_bus),
        .swap_req_i         (swap_req),
        .swap_done_o        (swap_done),
        .clr_req_i          (clr_req),
        .clr_busy_o         (clr_busy),
        .front_page_o       (front_page),
        .mem_addr_o         (mem_addr),
        .mem_we_o           (mem_we),
        .mem_be_o           (mem_be),
        .mem_wdata_o        (mem_wdata),
        .mem_rdata_i        (mem_rdata)
    );

    // Reference contents of both pages as the host and clear sequencer intend them.
    word_t gold [2*NWORDS];

    // Single-port synchronous RAM, 1-cycle read latency, per-pixel write enables.
    word_t ram [2*NWORDS];
    bit    ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 2*NWORDS; i++) ram[i] <= gold[i];
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            if (mem_be[1]) ram[mem_addr][WORD_W-1:PIX_W] <= mem_wdata[WORD_W-1:PIX_W];
            if (mem_be[0]) ram[mem_addr][PIX_W-1:0]      <= mem_wdata[PIX_W-1:0];
        end
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              due;
        logic [ADDR_W:0] addr;
        logic [1:0]      be;
        word_t           data;
    } exp_t;

    exp_t rd_addr_q[$];
    exp_t rd_data_q[$];
    exp_t wr_q[$];

    // Frame-level model state.
    bit m_front, m_pending, m_swap_done;
    int m_clear_left, m_clr_idx;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a RAM access or read data.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (rd_addr_q.size() != 0 && rd_addr_q[0].due <= cyc) begin
                    e = rd_addr_q.pop_front();
                    check("scan_mem_port", 64'({mem_we, mem_addr}), 64'({1'b0, e.addr}));
                end
                if (scan_rvalid) begin
                    check("scan_rvalid_expected", 64'(rd_data_q.size() != 0), 64'(1));
                    if (rd_data_q.size() != 0) begin
                        e = rd_data_q.pop_front();
                        check("scan_rdata_cycle", 64'(cyc), 64'(e.due));
                        check("scan_rdata", 64'(scan_rdata), 64'(e.data));
                    end
                end else if (rd_data_q.size() != 0 && rd_data_q[0].due <= cyc) begin
                    check("scan_rvalid", 64'(scan_rvalid), 64'(1));
                    void'(rd_data_q.pop_front());
                end
                if (mem_we) begin
                    check("mem_we_expected", 64'(wr_q.size() != 0), 64'(1));
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        check("mem_wr_cycle", 64'(cyc), 64'(e.due));
                        check("mem_wr", 64'({mem_addr, mem_be, mem_wdata}), 64'({e.addr, e.be, e.data}));
                    end
                end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
                    check("mem_we", 64'(mem_we), 64'(1));
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    task automatic idle_inputs();
        scan_req         = 1'b0;
        scan_addr        = '0;
        scan_frame_start = 1'b0;
        swap_req         = 1'b0;
        clr_req          = 1'b0;
        wr_bus.wr_valid  = 1'b0;
        wr_bus.wr_addr   = '0;
        wr_bus.wr_be     = 2'b00;
        wr_bus.wr_data   = '0;
    endtask

    // Called at a negedge with this cycle's inputs driven; checks, updates the model,
    // and returns at the next negedge.
    task automatic tick();
        bit              busy0;
        logic [ADDR_W:0] a;
        exp_t            e;
        #1;
        busy0 = (m_clear_left != 0);
        check("clr_busy",   64'(clr_busy),        64'(busy0));
        check("front_page", 64'(front_page),      64'(m_front));
        check("swap_done",  64'(swap_done),       64'(m_swap_done));
        check("wr_ready",   64'(wr_bus.wr_ready), 64'(!scan_req && !busy0));

        if (scan_req) begin
            a = {m_front, scan_addr};
            e = '{due: cyc + 1, addr: a, be: 2'b00, data: gold[a]};
            rd_addr_q.push_back(e);
            e.due = cyc + 2;
            rd_data_q.push_back(e);
        end else if (busy0) begin
            a = {!m_front, addr_t'(m_clr_idx)};
            wr_q.push_back('{due: cyc + 1, addr: a, be: 2'b11, data: {CLR, CLR}});
            m_clr_idx++;
            m_clear_left--;
        end else if (wr_bus.wr_valid) begin
            a = {!m_front, wr_bus.wr_addr};
            wr_q.push_back('{due: cyc + 1, addr: a, be: wr_bus.wr_be, data: wr_bus.wr_data});
            if (wr_bus.wr_be[1]) gold[a][WORD_W-1:PIX_W] = wr_bus.wr_data[WORD_W-1:PIX_W];
            if (wr_bus.wr_be[0]) gold[a][PIX_W-1:0]      = wr_bus.wr_data[PIX_W-1:0];
        end

        m_swap_done = 1'b0;
        if (scan_frame_start && (m_pending || swap_req) && !busy0) begin
            m_front     = !m_front;
            m_pending   = 1'b0;
            m_swap_done = 1'b1;
        end else if (swap_req) begin
            m_pending = 1'b1;
        end

        // The whole back page is the clear's target; its final contents are known up front.
        if (clr_req && !busy0) begin
            m_clear_left = NWORDS;
            m_clr_idx    = 0;
            for (int i = 0; i < NWORDS; i++) gold[{!m_front, addr_t'(i)}] = {CLR, CLR};
        end
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_addr_q.delete();
        rd_data_q.delete();
        wr_q.delete();
        m_front      = 1'b0;
        m_pending    = 1'b0;
        m_swap_done  = 1'b0;
        m_clear_left = 0;
        m_clr_idx    = 0;
        #1;
        check("reset_ctrl", 64'({scan_rvalid, swap_done, clr_busy, front_page, mem_we, mem_be, mem_addr}), 64'(0));
        check("reset_rdata", 64'(scan_rdata), 64'(0));
        check("reset_wdata", 64'(mem_wdata), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int busy_cnt;
        int mism;
        for (int i = 0; i < 2*NWORDS; i++) gold[i] = word_t'({$urandom, $urandom});
        gold[12'h040] = 48'hFF0000_00FF00;
        idle_inputs();
        #2;
        do_reset();

        // Directed scan read from page 0.
        scan_req  = 1'b1;
        scan_addr = 11'h040;
        tick();
        idle_ticks(4);

        // Host write blocked by scan, then accepted into the back page.
        scan_req        = 1'b1;
        scan_addr       = 11'h123;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = 11'h005;
        wr_bus.wr_be    = 2'b10;
        wr_bus.wr_data  = {24'h123456, 24'hABCDEF};
        tick();
        scan_req = 1'b0;
        tick();
        check("tp_host_write_port", 64'({mem_we, mem_be, mem_addr}), 64'({1'b1, 2'b10, 12'h805}));
        idle_ticks(3);

        // Clear with scan on every other cycle, starting with the first CLEAR cycle.
        clr_req = 1'b1;
        tick();
        idle_inputs();
        busy_cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            scan_req  = (i % 2 == 0);
            scan_addr = addr_t'($urandom);
            if (clr_busy) busy_cnt++;
            tick();
            if (m_clear_left == 0) break;
        end
        check("tp_clr_busy_len", 64'(busy_cnt), 64'(4096));
        idle_ticks(3);

        // Reset in the middle of a clear (counter at 100), then restore page 1.
        clr_req = 1'b1;
        tick();
        idle_ticks(100);
        do_reset();
        idle_ticks(2);
        clr_req = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 3000 && m_clear_left != 0; i++) tick();
        idle_ticks(3);

        // Swap request at relative cycle 10, frame start at 50.
        for (int i = 0; i < 60; i++) begin
            if (i == 50) check("tp_swap_front_before", 64'(front_page), 64'(0));
            if (i == 51) begin
                check("tp_swap_front_after", 64'(front_page), 64'(1));
                check("tp_swap_done", 64'(swap_done), 64'(1));
            end
            scan_req         = 1'($urandom_range(0, 1));
            scan_addr        = addr_t'($urandom);
            swap_req         = (i == 10);
            scan_frame_start = (i == 50);
            tick();
        end
        idle_ticks(2);

        // Swap requested during a clear: flip waits for the first frame start after it.
        clr_req = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 5000; i++) begin
            if (i == 101) check("tp_no_flip_mid_clear", 64'(front_page), 64'(1));
            scan_req         = ($urandom_range(0, 3) == 0);
            scan_addr        = addr_t'($urandom);
            swap_req         = (i == 5);
            scan_frame_start = (i == 100);
            tick();
            if (i > 101 && m_clear_left == 0) break;
        end
        idle_ticks(10);
        scan_frame_start = 1'b1;
        tick();
        check("tp_flip_after_clear", 64'({front_page, swap_done}), 64'({1'b0, 1'b1}));
        idle_ticks(2);

        // Randomized mixed traffic.
        for (int i = 0; i < 4000; i++) begin
            scan_req         = 1'($urandom_range(0, 1));
            scan_addr        = addr_t'($urandom);
            wr_bus.wr_valid  = 1'($urandom_range(0, 1));
            wr_bus.wr_addr   = addr_t'($urandom);
            wr_bus.wr_be     = 2'($urandom);
            wr_bus.wr_data   = word_t'({$urandom, $urandom});
            swap_req         = ($urandom_range(0, 39) == 0);
            scan_frame_start = ($urandom_range(0, 49) == 0);
            clr_req          = ($urandom_range(0, 1499) == 0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3000 && m_clear_left != 0; i++) tick();
        idle_ticks(5);

        check("sb_reads_drained",  64'(rd_data_q.size()), 64'(0));
        check("sb_writes_drained", 64'(wr_q.size()), 64'(0));
        mism = 0;
        for (int i = 0; i < 2*NWORDS; i++) if (ram[i] !== gold[i]) mism++;
        check("ram_contents_mismatches", 64'(mism), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
